// File: rtl/ex_wb_skid_register.sv
// -----------------------------------------------------------------------------
// ex_wb_skid_register
//
// EX->WB pipeline register with a valid/ready handshake and a one-entry skid
// buffer. The write-back stage can stall (wb_ready=0) without the EX stage
// losing a result that was already offered in the same cycle.
//
// Storage:
//   M (main)  : drives the WB outputs directly.
//   S (skid)  : catches one EX entry that arrives while M is stalled.
// Entries leave strictly in order M then S. Nothing is duplicated or lost.
//
// Ports:
//   clk              rising-edge clock for all state
//   reset            asynchronous, active-low reset
//   ex_valid         EX presents an entry this cycle
//   ex_ready         block can accept an entry (registered: skid is empty)
//   ex_data          ALU result
//   ex_opc           instruction code
//   ex_regwrite      entry is to be written to the register file
//   ex_rd            destination register address
//   wb_valid         M holds a valid entry for WB
//   wb_ready         WB consumes the current entry this cycle
//   Write_Data       M data to the register file
//   Instruction_Code M instruction code
//   RegWrite         register-file write enable (gated by wb_valid)
//   wb_rd            M destination register address
//   flush            synchronous squash of all held entries
//   retired          wrapping count of entries consumed by WB
// -----------------------------------------------------------------------------
module ex_wb_skid_register #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 3,
  parameter int RADDR_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic [OPC_W-1:0]   ex_opc,
  input  logic               ex_regwrite,
  input  logic [RADDR_W-1:0] ex_rd,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DATA_W-1:0]  Write_Data,
  output logic [OPC_W-1:0]   Instruction_Code,
  output logic               RegWrite,
  output logic [RADDR_W-1:0] wb_rd,
  input  logic               flush,
  output logic [CNT_W-1:0]   retired
);

  // Main register M
  logic               m_valid_q,    m_valid_d;
  logic [DATA_W-1:0]  m_data_q,     m_data_d;
  logic [OPC_W-1:0]   m_opc_q,      m_opc_d;
  logic               m_regwrite_q, m_regwrite_d;
  logic [RADDR_W-1:0] m_rd_q,       m_rd_d;

  // Skid register S
  logic               s_valid_q,    s_valid_d;
  logic [DATA_W-1:0]  s_data_q,     s_data_d;
  logic [OPC_W-1:0]   s_opc_q,      s_opc_d;
  logic               s_regwrite_q, s_regwrite_d;
  logic [RADDR_W-1:0] s_rd_q,       s_rd_d;

  logic [CNT_W-1:0]   retired_q,    retired_d;

  logic ex_xfer;
  logic wb_xfer;
  logic m_free;

  // ex_ready comes straight from the skid valid flop, so it is registered
  // and never depends combinationally on wb_ready.
  assign ex_ready = ~s_valid_q;
  assign ex_xfer  = ex_valid & ex_ready;
  assign wb_xfer  = m_valid_q & wb_ready;
  // M can take a new entry when it is empty or being drained this cycle.
  assign m_free   = ~m_valid_q | wb_ready;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_opc_d      = m_opc_q;
    m_regwrite_d = m_regwrite_q;
    m_rd_d       = m_rd_q;
    s_valid_d    = s_valid_q;
    s_data_d     = s_data_q;
    s_opc_d      = s_opc_q;
    s_regwrite_d = s_regwrite_q;
    s_rd_d       = s_rd_q;

    if (flush) begin
      // Squash only the valid bits; stale payload is harmless because the
      // outputs are qualified by wb_valid.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        // Skid is older than anything EX could offer (ex_ready=0 now).
        m_valid_d    = 1'b1;
        m_data_d     = s_data_q;
        m_opc_d      = s_opc_q;
        m_regwrite_d = s_regwrite_q;
        m_rd_d       = s_rd_q;
        s_valid_d    = 1'b0;
      end else if (ex_xfer) begin
        m_valid_d    = 1'b1;
        m_data_d     = ex_data;
        m_opc_d      = ex_opc;
        m_regwrite_d = ex_regwrite;
        m_rd_d       = ex_rd;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (ex_xfer) begin
      // M stalled: park the new entry in the skid slot.
      s_valid_d    = 1'b1;
      s_data_d     = ex_data;
      s_opc_d      = ex_opc;
      s_regwrite_d = ex_regwrite;
      s_rd_d       = ex_rd;
    end

    // Counts consumption even in a flush cycle; wraps naturally.
    retired_d = retired_q + CNT_W'(wb_xfer);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_opc_q      <= '0;
      m_regwrite_q <= 1'b0;
      m_rd_q       <= '0;
      s_valid_q    <= 1'b0;
      s_data_q     <= '0;
      s_opc_q      <= '0;
      s_regwrite_q <= 1'b0;
      s_rd_q       <= '0;
      retired_q    <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_opc_q      <= m_opc_d;
      m_regwrite_q <= m_regwrite_d;
      m_rd_q       <= m_rd_d;
      s_valid_q    <= s_valid_d;
      s_data_q     <= s_data_d;
      s_opc_q      <= s_opc_d;
      s_regwrite_q <= s_regwrite_d;
      s_rd_q       <= s_rd_d;
      retired_q    <= retired_d;
    end
  end

  assign wb_valid         = m_valid_q;
  assign Write_Data       = m_data_q;
  assign Instruction_Code = m_opc_q;
  // Never request a register-file write for an invalid entry.
  assign RegWrite         = m_valid_q & m_regwrite_q;
  assign wb_rd            = m_rd_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_ex_wb_skid_register.sv
module tb_ex_wb_skid_register;

  logic       clk;
  logic       reset;
  logic       ex_valid;
  logic       ex_ready;
  logic [7:0] ex_data;
  logic [2:0] ex_opc;
  logic       ex_regwrite;
  logic [2:0] ex_rd;
  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] Write_Data;
  logic [2:0] Instruction_Code;
  logic       RegWrite;
  logic [2:0] wb_rd;
  logic       flush;
  logic [15:0] retired;

  // Second instance with a 4-bit counter, sharing all inputs, for wrap checks
  logic       ex_ready4;
  logic       wb_valid4;
  logic [7:0] wd4;
  logic [2:0] ic4;
  logic       rw4;
  logic [2:0] rd4;
  logic [3:0] retired4;

  int n_vec;
  int n_bad;
  int exp_ret;

  ex_wb_skid_register dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_data(ex_data), .ex_opc(ex_opc), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .Write_Data(Write_Data), .Instruction_Code(Instruction_Code),
    .RegWrite(RegWrite), .wb_rd(wb_rd),
    .flush(flush), .retired(retired)
  );

  ex_wb_skid_register #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready4),
    .ex_data(ex_data), .ex_opc(ex_opc), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .wb_valid(wb_valid4), .wb_ready(wb_ready),
    .Write_Data(wd4), .Instruction_Code(ic4),
    .RegWrite(rw4), .wb_rd(rd4),
    .flush(flush), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [7:0] d;
    logic       rw;
    logic [2:0] rd;
    logic       wr;
    logic       fl;
    logic       e_rdy;
    logic       e_wbv;
    logic [7:0] e_d;
    logic       e_rw;
    logic [2:0] e_rd;
    int         inc;   // WB transfers happening at this edge
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic ev, logic [7:0] d, logic rw, logic [2:0] rd,
                              logic wr, logic fl, logic e_rdy, logic e_wbv,
                              logic [7:0] e_d, logic e_rw, logic [2:0] e_rd, int inc);
    vec_t v;
    v.ev = ev; v.d = d; v.rw = rw; v.rd = rd; v.wr = wr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_wbv = e_wbv; v.e_d = e_d; v.e_rw = e_rw; v.e_rd = e_rd;
    v.inc = inc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after an edge, take the next edge, sample 1 ns later.
  task automatic step(logic ev, logic [7:0] d, logic rw, logic [2:0] rd,
                      logic wr, logic fl, int inc);
    ex_valid = ev; ex_data = d; ex_opc = d[2:0]; ex_regwrite = rw; ex_rd = rd;
    wb_ready = wr; flush = fl;
    @(posedge clk);
    #1;
    exp_ret += inc;
  endtask

  task automatic check_outs(string tag, logic e_rdy, logic e_wbv, logic [7:0] e_d,
                            logic e_rw, logic [2:0] e_rd);
    logic [31:0] er16;
    logic [31:0] er4;
    er16 = 32'(exp_ret) & 32'hFFFF;
    er4  = 32'(exp_ret) & 32'hF;
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(e_rdy));
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(e_wbv));
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(e_rw));
    if (e_wbv) begin
      chk({tag, ".Write_Data"}, 32'(Write_Data), 32'(e_d));
      chk({tag, ".Instruction_Code"}, 32'(Instruction_Code), 32'(e_d[2:0]));
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(e_rd));
    end
    chk({tag, ".retired"}, 32'(retired), er16);
    chk({tag, ".retired4"}, 32'(retired4), er4);
    $display("%s: ex_ready=%0b wb_valid=%0b WD=%02h RW=%0b rd=%0d retired=%0d retired4=%0d",
             tag, ex_ready, wb_valid, Write_Data, RegWrite, wb_rd, retired, retired4);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_ret = 0;

    //            ev  d      rw rd wr fl  rdy wbv e_d   erw erd inc
    // Backpressure: 0x11, 0x22 stall; 0x33 held off; then drain in order
    tbl[0]  = mk(1, 8'h11, 1, 1, 0, 0,   1, 1, 8'h11, 1, 1, 0);
    tbl[1]  = mk(1, 8'h22, 1, 2, 0, 0,   0, 1, 8'h11, 1, 1, 0);
    tbl[2]  = mk(1, 8'h33, 1, 3, 0, 0,   0, 1, 8'h11, 1, 1, 0);
    tbl[3]  = mk(1, 8'h33, 1, 3, 0, 0,   0, 1, 8'h11, 1, 1, 0);
    tbl[4]  = mk(1, 8'h33, 1, 3, 0, 0,   0, 1, 8'h11, 1, 1, 0);
    tbl[5]  = mk(1, 8'h33, 1, 3, 1, 0,   1, 1, 8'h22, 1, 2, 1);
    tbl[6]  = mk(1, 8'h33, 1, 3, 1, 0,   1, 1, 8'h33, 1, 3, 1);
    tbl[7]  = mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 1);
    // Flush while full: M=0x44, S=0x55, flush with 0x66 offered
    tbl[8]  = mk(1, 8'h44, 1, 4, 0, 0,   1, 1, 8'h44, 1, 4, 0);
    tbl[9]  = mk(1, 8'h55, 1, 5, 0, 0,   0, 1, 8'h44, 1, 4, 0);
    tbl[10] = mk(1, 8'h66, 1, 6, 0, 1,   1, 0, 8'h00, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    // Invalid-write gating
    tbl[12] = mk(0, 8'h00, 1, 7, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 1, 7, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[14] = mk(0, 8'h00, 1, 7, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[15] = mk(0, 8'h00, 1, 7, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[16] = mk(0, 8'h00, 1, 7, 1, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[17] = mk(1, 8'h77, 0, 6, 1, 0,   1, 1, 8'h77, 0, 6, 0);
    tbl[18] = mk(0, 8'h00, 0, 0, 1, 0,   1, 0, 8'h00, 0, 0, 1);
    // Flush coinciding with a WB transfer still counts that transfer
    tbl[19] = mk(1, 8'h88, 1, 2, 0, 0,   1, 1, 8'h88, 1, 2, 0);
    tbl[20] = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 1);

    // Reset held with EX driving 0xA5: nothing must load
    reset = 1'b0;
    ex_valid = 1'b1; ex_data = 8'hA5; ex_opc = 3'd5; ex_regwrite = 1'b1; ex_rd = 3'd5;
    wb_ready = 1'b1; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.RegWrite", 32'(RegWrite), 32'd0);
    chk("rst.Write_Data", 32'(Write_Data), 32'd0);
    chk("rst.Instruction_Code", 32'(Instruction_Code), 32'd0);
    chk("rst.retired", 32'(retired), 32'd0);
    $display("reset: wb_valid=%0b RW=%0b WD=%02h IC=%0d retired=%0d",
             wb_valid, RegWrite, Write_Data, Instruction_Code, retired);
    ex_valid = 1'b0;
    reset = 1'b1;
    step(0, 8'h00, 0, 0, 1, 0, 0);
    check_outs("post_reset", 1, 0, 8'h00, 0, 0);

    // Streaming 0x01..0x10, one per cycle, visible one cycle later
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] d;
      d = 8'(i);
      step(1, d, 1, d[2:0], 1, 0, (i == 1) ? 0 : 1);
      check_outs($sformatf("stream%0d", i), 1, 1, d, 1, d[2:0]);
    end
    step(0, 8'h00, 0, 0, 1, 0, 1);
    check_outs("stream_drain", 1, 0, 8'h00, 0, 0);
    chk("stream.retired16", 32'(retired), 32'd16);
    chk("stream.retired4_wrap", 32'(retired4), 32'd0);

    // Table-driven backpressure / flush / gating sequences
    for (int k = 0; k < 21; k++) begin
      step(tbl[k].ev, tbl[k].d, tbl[k].rw, tbl[k].rd, tbl[k].wr, tbl[k].fl, tbl[k].inc);
      check_outs($sformatf("vec%0d", k), tbl[k].e_rdy, tbl[k].e_wbv,
                 tbl[k].e_d, tbl[k].e_rw, tbl[k].e_rd);
    end
    // 16 streamed + 3 drained + 1 (0x77) + 1 (0x88) = 21 -> 5 in 4 bits
    chk("total.retired", 32'(retired), 32'd21);
    chk("total.retired4", 32'(retired4), 32'd5);

    // Async reset mid-stall with skid full, no clock edge involved
    step(1, 8'hAA, 1, 1, 0, 0, 0);
    step(1, 8'hBB, 1, 2, 0, 0, 0);
    check_outs("stall_full", 0, 1, 8'hAA, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    exp_ret = 0;
    chk("async.wb_valid", 32'(wb_valid), 32'd0);
    chk("async.ex_ready", 32'(ex_ready), 32'd1);
    chk("async.RegWrite", 32'(RegWrite), 32'd0);
    chk("async.retired", 32'(retired), 32'd0);
    chk("async.retired4", 32'(retired4), 32'd0);
    $display("async_reset: wb_valid=%0b ex_ready=%0b RW=%0b retired=%0d",
             wb_valid, ex_ready, RegWrite, retired);
    #3;
    reset = 1'b1;
    step(0, 8'h00, 0, 0, 1, 0, 0);
    check_outs("after_async", 1, 0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_wb_skid_register.md
Name: ex_wb_skid_register

Overview:
- Parametrised EX→WB pipeline register for the pipelined core; the next generation of the fixed 8-bit/3-bit stage register.
- Adds valid/ready handshaking with a one-entry skid buffer, so a stalled write-back stage never drops an EX result.
- Adds synchronous flush, a destination-register field, and a retired-instruction counter.
- Sits between the ALU/EX stage and the register-file write port.

Parameters:
DATA_W, 8, width of ALU result / write data
OPC_W, 3, width of instruction code
RADDR_W, 3, width of destination register address
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset
ex_valid  input  1  EX stage presents a result this cycle
ex_ready  output  1  block can accept (registered, = skid empty)
ex_data  input  DATA_W  ALU result
ex_opc  input  OPC_W  instruction code
ex_regwrite  input  1  result is to be written to the register file
ex_rd  input  RADDR_W  destination register address
wb_valid  output  1  Write_Data/Instruction_Code/rd valid for WB
wb_ready  input  1  WB stage consumes the current entry
Write_Data  output  DATA_W  data to register file
Instruction_Code  output  OPC_W  code to WB
RegWrite  output  1  register-file write enable
wb_rd  output  RADDR_W  destination address
flush  input  1  synchronous squash of all held entries
retired  output  CNT_W  count of entries consumed by WB

Behaviour:
- Reset is asynchronous and active-low: clk and reset, reset==0 clears all state immediately, independent of clk.
- Reset values: wb_valid=0, Write_Data=0, Instruction_Code=0 (driven low, never Z), RegWrite=0, wb_rd=0, retired=0, skid empty, ex_ready=1 in the first cycle after release.
- Storage: main register M (drives WB outputs) and skid register S. Each has a valid bit plus {data, opc, regwrite, rd}.
- ex_ready = !S.valid, registered. An EX transfer occurs on ex_valid & ex_ready. A WB transfer occurs on wb_valid & wb_ready.
- Latency: with M empty or draining, an accepted EX entry appears on the WB outputs one cycle later (same as the old stage register).
- Per-edge update, when flush=0:
  - M empty or WB transfer, S valid → M←S, S cleared. An EX transfer in the same cycle is impossible because ex_ready=0.
  - M empty or WB transfer, S empty, EX transfer → M←EX, M.valid=1.
  - M empty or WB transfer, S empty, no EX transfer → M.valid←0.
  - M valid, no WB transfer, EX transfer → S←EX, S.valid=1, so ex_ready=0 next cycle.
  - M valid, no WB transfer, no EX transfer → hold.
- Ordering is strictly FIFO (M before S). There is no duplication and no loss.
- RegWrite = M.valid & M.regwrite, so a write is never issued for an invalid entry. Write_Data, Instruction_Code and wb_rd show the last loaded payload even when invalid; their value is don't-care when wb_valid=0.
- Flush=1 at an edge: M.valid←0 and S.valid←0. Any simultaneous EX transfer is dropped. ex_ready=1 next cycle. The retired counter still counts a WB transfer in that same cycle. Payload registers need not clear.
- retired increments by 1 on each WB transfer and wraps from 2^CNT_W−1 to 0. No saturation.
- Reset mid-operation: all entries discarded, outputs return to reset values asynchronously.
- Throughput: 1 entry/cycle sustained while wb_ready=1. Full condition = M and S both valid.

Test Plan:
- Reset: hold reset=0 with ex_valid=1, ex_data=0xA5, then pulse clk → wb_valid=0, RegWrite=0, Write_Data=0, Instruction_Code=0, retired=0. Release reset → ex_ready=1.
- Streaming: wb_ready=1, feed ex_data 0x01..0x10 on consecutive cycles, ex_regwrite=1, rd=i[2:0] → identical sequence on Write_Data, one cycle later, RegWrite=1 each cycle, retired=16.
- Backpressure: send 0x11 and 0x22 back-to-back with wb_ready=0 → ex_ready drops after the second. Then 3 cycles of held ex_valid with 0x33 → not accepted. Raise wb_ready → outputs 0x11, 0x22, 0x33 in order, no loss or duplicate.
- Flush while full: M=0x44, S=0x55, assert flush with ex_valid=1, ex_data=0x66 → next cycle wb_valid=0, ex_ready=1, 0x66 never appears, retired unchanged.
- Invalid-write gating: ex_valid=0, ex_regwrite=1 for 5 cycles → RegWrite stays 0. Then an entry with ex_regwrite=0 → wb_valid=1, RegWrite=0.
- Counter wrap, CNT_W=4: 17 WB transfers → retired=1. Async reset asserted mid-stall with S full → wb_valid and ex_ready return to 0 and 1 respectively without a clock edge.
